// File: rtl/debounce_multi.sv
// N-channel button debouncer: synchroniser, stability FSM, clean level,
// rise/fall strobes and a one-shot long-press strobe per channel.
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 100,
  parameter int LONG_CYCLES   = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_press
);

  localparam int CW = $clog2(LONG_CYCLES + 1);

  // state[1] doubles as the registered clean level
  localparam logic [1:0] LO     = 2'b00;
  localparam logic [1:0] CHK_HI = 2'b01;
  localparam logic [1:0] HI     = 2'b10;
  localparam logic [1:0] CHK_LO = 2'b11;

  localparam logic [CW-1:0] QMAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LMAX  = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LFIRE = CW'(LONG_CYCLES - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
    return (v >= lim) ? lim : v + CW'(1);
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync;
    logic [1:0]             state;
    logic [CW-1:0]          qcnt;
    logic [CW-1:0]          lcnt;
    logic                   rise_p1;
    logic                   fall_p1;
    logic                   long_p1;

    // Stage 0: synchroniser chain
    always_ff @(posedge clk) begin
      if (rst) sync_p0 <= '0;
      else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], noisy_in[i]};
    end

    assign sync = sync_p0[SYNC_STAGES-1];

    // Stage 1: stability FSM; qcnt qualifies a level change, lcnt times the press
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= LO;
        qcnt    <= '0;
        lcnt    <= '0;
        rise_p1 <= 1'b0;
        fall_p1 <= 1'b0;
        long_p1 <= 1'b0;
      end else begin
        rise_p1 <= 1'b0;
        fall_p1 <= 1'b0;
        long_p1 <= 1'b0;
        case (state)
          LO: begin
            if (sync) begin
              state <= CHK_HI;
              qcnt  <= CW'(1);
            end
          end
          CHK_HI: begin
            if (!sync) begin
              state <= LO;
              qcnt  <= '0;
            end else if (qcnt == QMAX) begin
              state   <= HI;
              qcnt    <= '0;
              lcnt    <= '0;
              rise_p1 <= 1'b1;
            end else begin
              qcnt <= sat_inc(qcnt, QMAX);
            end
          end
          HI: begin
            lcnt    <= sat_inc(lcnt, LMAX);
            long_p1 <= (lcnt == LFIRE);
            if (!sync) begin
              state <= CHK_LO;
              qcnt  <= CW'(1);
            end
          end
          CHK_LO: begin
            // press timing keeps running while a release is being qualified
            lcnt    <= sat_inc(lcnt, LMAX);
            long_p1 <= (lcnt == LFIRE);
            if (sync) begin
              state <= HI;
            end else if (qcnt == QMAX) begin
              state   <= LO;
              qcnt    <= '0;
              lcnt    <= '0;
              long_p1 <= 1'b0;
              fall_p1 <= 1'b1;
            end else begin
              qcnt <= sat_inc(qcnt, QMAX);
            end
          end
          default: state <= LO;
        endcase
      end
    end

    assign clean_out[i]  = state[1];
    assign rise_pulse[i] = rise_p1;
    assign fall_pulse[i] = fall_p1;
    assign long_press[i] = long_p1;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed vector table, hand-written corner sequences,
// and randomized stimulus checked every cycle against a run-length reference model.
module tb_debounce_multi;

  localparam int N_CH   = 2;
  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int LONG   = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] noisy_in;
  logic [N_CH-1:0] clean_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic [N_CH-1:0] long_press;

  debounce_multi #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [1:0] in;
    int         ncyc;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] lng;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: the clean level flips once STABLE consecutive
  // synchroniser-delayed samples disagree with it; long press fires LONG
  // cycles after a rise unless the release has completed by then.
  int m_dly [N_CH][SYNC];
  int m_clean [N_CH];
  int m_run [N_CH];
  int m_age [N_CH];
  logic [N_CH-1:0] e_clean, e_rise, e_fall, e_long;

  task automatic model_step();
    for (int ch = 0; ch < N_CH; ch++) begin
      int seen;
      e_rise[ch] = 1'b0;
      e_fall[ch] = 1'b0;
      e_long[ch] = 1'b0;
      if (rst) begin
        for (int s = 0; s < SYNC; s++) m_dly[ch][s] = 0;
        m_clean[ch] = 0;
        m_run[ch]   = 0;
        m_age[ch]   = 0;
      end else begin
        seen = m_dly[ch][SYNC-1];
        for (int s = SYNC - 1; s > 0; s--) m_dly[ch][s] = m_dly[ch][s-1];
        m_dly[ch][0] = noisy_in[ch] ? 1 : 0;
        if (seen != m_clean[ch]) m_run[ch]++;
        else                     m_run[ch] = 0;
        if (m_run[ch] == STABLE) begin
          m_clean[ch] = 1 - m_clean[ch];
          m_run[ch]   = 0;
          if (m_clean[ch] == 1) begin
            e_rise[ch] = 1'b1;
            m_age[ch]  = 0;
          end else begin
            e_fall[ch] = 1'b1;
          end
        end else if (m_clean[ch] == 1 && m_age[ch] < LONG) begin
          m_age[ch]++;
          if (m_age[ch] == LONG) e_long[ch] = 1'b1;
        end
      end
      e_clean[ch] = (m_clean[ch] == 1);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    tests++;
    if ({clean_out, rise_pulse, fall_pulse, long_press} !== {e_clean, e_rise, e_fall, e_long}) begin
      fails++;
      $display("FAIL model t=%0t got c=%b r=%b f=%b l=%b want c=%b r=%b f=%b l=%b", $time,
               clean_out, rise_pulse, fall_pulse, long_press, e_clean, e_rise, e_fall, e_long);
    end
  endtask

  task automatic check(input int id, input logic [1:0] c, input logic [1:0] r,
                       input logic [1:0] f, input logic [1:0] l);
    tests++;
    if ({clean_out, rise_pulse, fall_pulse, long_press} !== {c, r, f, l}) begin
      fails++;
      $display("FAIL step%0d got c=%b r=%b f=%b l=%b want c=%b r=%b f=%b l=%b", id,
               clean_out, rise_pulse, fall_pulse, long_press, c, r, f, l);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] in, input int n,
                              input logic [1:0] c, input logic [1:0] ri,
                              input logic [1:0] f, input logic [1:0] l);
    vec_t v;
    v.r = r; v.in = in; v.ncyc = n; v.clean = c; v.rise = ri; v.fall = f; v.lng = l;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [N_CH-1:0] nv;
    int hold [N_CH];

    rst      = 1'b1;
    noisy_in = 2'b11;
    for (int ch = 0; ch < N_CH; ch++) begin
      for (int s = 0; s < SYNC; s++) m_dly[ch][s] = 0;
      m_clean[ch] = 0; m_run[ch] = 0; m_age[ch] = 0; hold[ch] = 0;
    end

    // reset with inputs high, then both channels rise 10 edges after release
    tbl.push_back(mk(1'b1, 2'b11, 3,  2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b11, 9,  2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b11, 1,  2'b11, 2'b11, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b11, 1,  2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 9,  2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 1,  2'b00, 2'b00, 2'b11, 2'b00));
    // short bursts on ch0 never qualify
    tbl.push_back(mk(1'b0, 2'b01, 3,  2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 2,  2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, 5,  2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 12, 2'b00, 2'b00, 2'b00, 2'b00));
    // ch0 held 15 cycles: rise then fall, no long press
    tbl.push_back(mk(1'b0, 2'b01, 9,  2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, 1,  2'b01, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, 5,  2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 9,  2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 1,  2'b00, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00));
    // ch1 long press 20 cycles after rise, glitch afterwards is ignored
    tbl.push_back(mk(1'b0, 2'b10, 9,  2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, 1,  2'b10, 2'b10, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, 19, 2'b10, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, 1,  2'b10, 2'b00, 2'b00, 2'b10));
    tbl.push_back(mk(1'b0, 2'b10, 1,  2'b10, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 3,  2'b10, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, 15, 2'b10, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 9,  2'b10, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 1,  2'b00, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00));
    // identical stimulus on both channels, then ch1 bounced alone
    tbl.push_back(mk(1'b0, 2'b11, 9,  2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b11, 1,  2'b11, 2'b11, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, 2,  2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b11, 2,  2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, 3,  2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b11, 2,  2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 9,  2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 1,  2'b00, 2'b00, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      rst      = tbl[i].r;
      noisy_in = tbl[i].in;
      repeat (tbl[i].ncyc) tick();
      check(i, tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].lng);
    end

    // reset while ch0 is high: no fall strobe, re-rise 10 edges after release
    rst = 1'b0; noisy_in = 2'b01;
    repeat (9) tick();
    check(100, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    check(101, 2'b01, 2'b01, 2'b00, 2'b00);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check(102, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    tick();
    check(103, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (8) tick();
    check(104, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    check(105, 2'b01, 2'b01, 2'b00, 2'b00);
    noisy_in = 2'b00;
    repeat (9) tick();
    check(106, 2'b01, 2'b00, 2'b00, 2'b00);
    tick();
    check(107, 2'b00, 2'b00, 2'b01, 2'b00);
    repeat (5) tick();

    // ch1 long press lands while its release is still being qualified
    noisy_in = 2'b10;
    repeat (9) tick();
    tick();
    check(200, 2'b10, 2'b10, 2'b00, 2'b00);
    repeat (15) tick();
    noisy_in = 2'b00;
    repeat (4) tick();
    check(201, 2'b10, 2'b00, 2'b00, 2'b00);
    tick();
    check(202, 2'b10, 2'b00, 2'b00, 2'b10);
    repeat (4) tick();
    check(203, 2'b10, 2'b00, 2'b00, 2'b00);
    tick();
    check(204, 2'b00, 2'b00, 2'b10, 2'b00);
    repeat (5) tick();

    // randomized segments of stable and bouncing levels, occasional reset
    for (int c = 0; c < 5000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int ch = 0; ch < N_CH; ch++) begin
        if (hold[ch] == 0) begin
          nv[ch]   = 1'($urandom_range(0, 1));
          hold[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(10, 60))
                                                 : int'($urandom_range(1, 6));
        end
        hold[ch]--;
      end
      noisy_in = nv;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
